instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the single-core matrix-multiplication processor. It is the reader side of the instruction RAM: it drives the RAM's read enable and byte address, collects each opcode and its in-line operand bytes, and presents one complete instruction per handshake to the core's decode/execute logic. It maintains the program counter, applies `jpnz` redirects resolved by the core, and stops on `endop`.

## Interface
- `OP_LDAC`, 8'd4: opcode followed by 2 operand bytes, first byte is the LSB.
- `OP_JPNZ`, 8'd42: opcode followed by 1 operand byte, the jump target address.
- `OP_ENDOP`, 8'd46: program terminator.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins execution at address 0. Honoured only in IDLE or HALT.
- `read_IRAM` output 1: instruction RAM read enable.
- `addr` output 8: instruction RAM byte address.
- `instr_in` input 8: instruction RAM data. It is valid in the cycle after `read_IRAM` is high.
- `instr_valid` output 1: a complete instruction is presented.
- `instr_ready` input 1: core accepts the presented instruction.
- `opcode` output 8: opcode byte of the presented instruction.
- `operand` output 16: operand bytes. `{byte2, byte1}` for `ldac`, `{8'd0, byte1}` for `jpnz`, 0 otherwise.
- `branch_taken` input 1: sampled only on the accept cycle of a `jpnz`. When 1, the jump is taken.
- `busy` output 1: high in every state except IDLE and HALT.
- `halted` output 1: high in HALT.

## Operation
- States:
  - IDLE
  - OP_REQ, OP_WAIT
  - B1_REQ, B1_WAIT
  - B2_REQ, B2_WAIT
  - ISSUE
  - HALT
- IDLE: on `start`, `pc` <= 0 and the unit moves to OP_REQ.
- Each *_REQ state:
  - `read_IRAM`=1 and `addr`=`pc`.
  - `pc` <= `pc`+1, wrapping modulo 256 (255 -> 0).
  - Moves to the matching *_WAIT state.
- Each *_WAIT state: `instr_in` is captured at the end of the cycle.
  - OP_WAIT: the byte goes to `opcode` and `operand` clears to 0. Next state is B1_REQ if the opcode is `ldac` or `jpnz`, otherwise ISSUE.
  - B1_WAIT: the byte goes to `operand[7:0]`. Next state is B2_REQ if the opcode is `ldac`, otherwise ISSUE.
  - B2_WAIT: the byte goes to `operand[15:8]`. Next state is ISSUE.
- ISSUE: `instr_valid`=1, and `opcode`/`operand` are held stable until `instr_ready`=1. On accept:
  - `endop`: go to HALT.
  - `jpnz` with `branch_taken`=1: `pc` <= `operand[7:0]`, then OP_REQ.
  - Anything else (including `jpnz` not taken): OP_REQ with `pc` unchanged.
- HALT: no RAM reads. `start` clears `halted`, sets `pc` <= 0, and moves to OP_REQ.
- Unknown opcodes, including `idle` (0), carry 0 operand bytes and are issued normally.
- `start` outside IDLE/HALT is ignored. Only `rst_n` aborts a running program.
- `read_IRAM` is 0 in every non-REQ state. `addr` holds its last driven value.

## Timing
- Reset values: all outputs are 0 (`read_IRAM`, `addr`, `instr_valid`, `opcode`, `operand`, `busy`, `halted`); state is IDLE and `pc`=0. Reset takes effect immediately and asynchronously, including mid-fetch and mid-ISSUE.
- Each byte costs 2 cycles, REQ then WAIT.
- Latency from entering OP_REQ to `instr_valid`: 2 cycles for 0-operand instructions, 4 for `jpnz`, 6 for `ldac`.
- With `start` in cycle 0: `read_IRAM` is high in cycle 1, and a 0-operand instruction has `instr_valid` high in cycle 3.
- On accept in cycle N, the next OP_REQ is in cycle N+1. The redirected address appears on `addr` in cycle N+1.
- `instr_valid` drops in the cycle after accept. It never stays high for two instructions without an intervening fetch.

## Test plan
- Program `clac`(19), `ldac` 0 0, `ldacm`(8), `endop`(46). Hold `instr_ready`=1 and pulse `start`. Required:
  - Issues, in order: 19/0, 4/16'h0000, 8/0, 46/0.
  - `addr` sequence 0,1,2,3,4,5.
  - `halted`=1 after the `endop` accept, with no further `read_IRAM`.
- `ldac` with bytes 8'd2 (first), 8'd1 (second) at addresses 12..14 -> `operand`=16'h0102, `opcode`=4.
- `jpnz` 26 at addresses 47..48:
  - Accepted with `branch_taken`=1 -> next `addr`=26.
  - Accepted with `branch_taken`=0 -> next `addr`=49.
- Backpressure: hold `instr_ready`=0 for 5 cycles during ISSUE -> `instr_valid`, `opcode` and `operand` stay stable and `read_IRAM` stays 0. Accept in the 6th cycle -> OP_REQ in the next cycle.
- Place a 0-operand opcode at address 255 -> the next fetch reads `addr` 0 (wrap). Then `start` during `busy` -> ignored, with no change to the `pc` sequence.
- Assert `rst_n`=0 during B1_WAIT -> all outputs 0 immediately. Release and pulse `start` -> fetch restarts at `addr` 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode and operand bytes from the
// instruction RAM and hands one complete instruction per handshake.
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        read_IRAM,
    output logic [7:0]  addr,
    input  logic [7:0]  instr_in,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    input  logic        branch_taken,
    output logic        busy,
    output logic        halted
);

    localparam logic [7:0] OP_LDAC  = 8'd4;
    localparam logic [7:0] OP_JPNZ  = 8'd42;
    localparam logic [7:0] OP_ENDOP = 8'd46;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OP_REQ,
        S_OP_WAIT,
        S_B1_REQ,
        S_B1_WAIT,
        S_B2_REQ,
        S_B2_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  pc;
    logic [7:0]  pc_nx;
    logic [7:0]  addr_q;
    logic        is_req;

    // Next-state and program-counter selection
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nx    = 8'd0;
                    state_nx = S_OP_REQ;
                end
            end
            S_OP_REQ: begin
                pc_nx    = pc + 8'd1;
                state_nx = S_OP_WAIT;
            end
            S_OP_WAIT: begin
                if (instr_in == OP_LDAC || instr_in == OP_JPNZ)
                    state_nx = S_B1_REQ;
                else
                    state_nx = S_ISSUE;
            end
            S_B1_REQ: begin
                pc_nx    = pc + 8'd1;
                state_nx = S_B1_WAIT;
            end
            S_B1_WAIT: begin
                if (opcode == OP_LDAC)
                    state_nx = S_B2_REQ;
                else
                    state_nx = S_ISSUE;
            end
            S_B2_REQ: begin
                pc_nx    = pc + 8'd1;
                state_nx = S_B2_WAIT;
            end
            S_B2_WAIT: begin
                state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (opcode == OP_ENDOP) begin
                        state_nx = S_HALT;
                    end else begin
                        if (opcode == OP_JPNZ && branch_taken)
                            pc_nx = operand[7:0];
                        state_nx = S_OP_REQ;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Status and RAM-side outputs decoded from the current state
    always_comb begin
        is_req = (state == S_OP_REQ) || (state == S_B1_REQ) ||
                 (state == S_B2_REQ);
        read_IRAM   = is_req;
        addr        = is_req ? pc : addr_q;
        instr_valid = (state == S_ISSUE);
        busy        = (state != S_IDLE) && (state != S_HALT);
        halted      = (state == S_HALT);
    end

    // State, program counter and held RAM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= 8'd0;
            addr_q <= 8'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (is_req)
                addr_q <= pc;
        end
    end

    // Capture RAM bytes into the instruction being assembled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode  <= 8'd0;
            operand <= 16'd0;
        end else begin
            unique case (state)
                S_OP_WAIT: begin
                    opcode  <= instr_in;
                    operand <= 16'd0;
                end
                S_B1_WAIT: operand[7:0]  <= instr_in;
                S_B2_WAIT: operand[15:8] <= instr_in;
                default: ;
            endcase
        end
    end

endmodule
